// File: rtl/musa_fetch_queue.sv
// MUSA instruction fetch stage: owns the PC, fetches words over imem req/ack, and feeds decode from a prefetch FIFO.
// Define FETCH_STATS_EN to add the saturating stat_fetched / stat_squashed counters.
module musa_fetch_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          redirect,
   input  logic [ADDR_WIDTH-1:0]         redirect_pc,
   output logic                          imem_req,
   output logic [ADDR_WIDTH-1:0]         imem_addr,
   input  logic                          imem_ack,
   input  logic [DATA_WIDTH-1:0]         imem_rdata,
   output logic                          instr_valid,
   input  logic                          instr_ready,
   output logic [DATA_WIDTH-1:0]         instr_out,
   output logic [ADDR_WIDTH-1:0]         instr_pc,
`ifdef FETCH_STATS_EN
   output logic [31:0]                   stat_fetched,
   output logic [31:0]                   stat_squashed,
`endif
   output logic [$clog2(DEPTH):0]        queue_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SQUASH} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] pc, pc_next, addr_q, addr_next;
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
   logic [PW-1:0]         rd_ptr, wr_ptr;
   logic [CW-1:0]         count, count_push;
   logic                  push, pop, drop;

   assign instr_valid = (count != '0);
   assign queue_count = count;
   assign instr_out   = data_mem[rd_ptr];
   assign instr_pc    = pc_mem[rd_ptr];
   assign imem_addr   = addr_q;

   // A flush always beats a pop; an ack is dropped if the request is stale or redirected this cycle.
   assign pop  = instr_valid && instr_ready && !redirect;
   assign push = (state == ST_WAIT) && imem_ack && !redirect;
   assign drop = imem_ack && ((state == ST_SQUASH) || ((state == ST_WAIT) && redirect));

   always_comb begin
      state_next = state;
      pc_next    = pc;
      addr_next  = addr_q;
      imem_req   = 1'b0;
      count_push = count + CW'(1) - CW'(pop);
      case (state)
         ST_IDLE: begin
            if (redirect) begin
               pc_next = redirect_pc;
            end else if (count < CW'(DEPTH)) begin
               addr_next  = pc;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            imem_req = 1'b1;
            if (redirect) begin
               pc_next    = redirect_pc;
               state_next = drop ? ST_IDLE : ST_SQUASH;
            end else if (imem_ack) begin
               pc_next = pc + ADDR_WIDTH'(1);
               if (count_push < CW'(DEPTH)) begin
                  addr_next = pc + ADDR_WIDTH'(1);
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_SQUASH: begin
            imem_req = 1'b1;
            if (redirect) begin
               pc_next = redirect_pc;
            end
            if (drop) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         pc     <= '0;
         addr_q <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else begin
         state  <= state_next;
         pc     <= pc_next;
         addr_q <= addr_next;
         if (redirect) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
         end else begin
            if (push) begin
               data_mem[wr_ptr] <= imem_rdata;
               pc_mem[wr_ptr]   <= addr_q;
               wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Only one request is ever in flight, so a push into a full queue means the FSM is broken.
   assert property (@(posedge clk) disable iff (rst) !(push && (count == CW'(DEPTH))));

`ifdef FETCH_STATS_EN
   logic [32:0] fetched_sum, squashed_sum;

   always_comb begin
      fetched_sum  = {1'b0, stat_fetched} + 33'(push);
      squashed_sum = {1'b0, stat_squashed} + 33'(drop) + (redirect ? 33'(count) : 33'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetched  <= '0;
         stat_squashed <= '0;
      end else begin
         stat_fetched  <= fetched_sum[32]  ? '1 : fetched_sum[31:0];
         stat_squashed <= squashed_sum[32] ? '1 : squashed_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_musa_fetch_queue.sv
// Self-checking bench for musa_fetch_queue: queue-level model checked every cycle plus directed literal checks.
module tb_musa_fetch_queue;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          imem_ack = 1'b0;
   logic [DW-1:0] imem_rdata = '0;
   logic          instr_ready = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          instr_valid;
   logic [DW-1:0] instr_out;
   logic [AW-1:0] instr_pc;
   logic [2:0]    queue_count;
`ifdef FETCH_STATS_EN
   logic [31:0]   stat_fetched;
   logic [31:0]   stat_squashed;
`endif

   musa_fetch_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr_out(instr_out),
      .instr_pc(instr_pc),
`ifdef FETCH_STATS_EN
      .stat_fetched(stat_fetched),
      .stat_squashed(stat_squashed),
`endif
      .queue_count(queue_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the prefetch queue contents, the address the next fresh request must use,
   // and whether the request currently on the bus has been made stale by a redirect.
   typedef struct {
      logic [DW-1:0] data;
      logic [AW-1:0] pc;
   } entry_t;

   entry_t        q[$];
   logic [AW-1:0] exp_addr = '0;
   logic [AW-1:0] stale_addr = '0;
   bit            stale = 1'b0;
   longint        m_fetched = 0;
   longint        m_squashed = 0;

   logic          s_rst = 1'b1, s_redirect = 1'b0, s_ack = 1'b0, s_ready = 1'b0, s_req = 1'b0;
   logic [AW-1:0] s_rpc = '0, s_addr = '0;
   logic [DW-1:0] s_rdata = '0;

   function automatic logic [31:0] sat32(input longint v);
      return (v > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   always @(posedge clk) begin
      if (s_rst) begin
         q.delete();
         exp_addr   = '0;
         stale      = 1'b0;
         stale_addr = '0;
         m_fetched  = 0;
         m_squashed = 0;
      end else begin
         if (q.size() != 0 && s_ready && !s_redirect) q.delete(0);
         if (s_req && s_ack) begin
            if (!stale && !s_redirect) begin
               q.push_back('{data: s_rdata, pc: s_addr});
               exp_addr = s_addr + 10'd1;
               m_fetched++;
            end else begin
               m_squashed++;
            end
            stale = 1'b0;
         end else if (s_req && s_redirect) begin
            if (!stale) stale_addr = s_addr;
            stale = 1'b1;
         end
         if (s_redirect) begin
            m_squashed += q.size();
            q.delete();
            exp_addr = s_rpc;
         end
      end
   end

   always @(negedge clk) begin
      s_rst      = rst;
      s_redirect = redirect;
      s_rpc      = redirect_pc;
      s_ack      = imem_ack;
      s_rdata    = imem_rdata;
      s_ready    = instr_ready;
      s_req      = imem_req;
      s_addr     = imem_addr;
      check("queue_count", 32'(queue_count), 32'(q.size()));
      check("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("instr_out", instr_out, q[0].data);
         check("instr_pc", 32'(instr_pc), 32'(q[0].pc));
      end
      if (imem_req) begin
         if (stale) check("imem_addr_squash", 32'(imem_addr), 32'(stale_addr));
         else       check("imem_addr", 32'(imem_addr), 32'(exp_addr));
      end
      if (q.size() == DEPTH) check("req_when_full", 32'(imem_req), 32'd0);
`ifdef FETCH_STATS_EN
      check("stat_fetched", stat_fetched, sat32(m_fetched));
      check("stat_squashed", stat_squashed, sat32(m_squashed));
`endif
   end

   // Memory responder and stimulus helpers.
   bit            auto_ack = 1'b0;
   int            ack_delay = 0;
   int            wait_cnt = 0;
   logic [9:0]    tag = '0;

   task automatic give_ack();
      imem_ack   = 1'b1;
      imem_rdata = {12'hABC, tag, imem_addr};
      tag        = tag + 10'd1;
   endtask

   task automatic respond();
      imem_ack = 1'b0;
      if (auto_ack && imem_req) begin
         if (wait_cnt >= ack_delay) begin
            give_ack();
            wait_cnt = 0;
         end else begin
            wait_cnt++;
         end
      end else if (!imem_req) begin
         wait_cnt = 0;
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      redirect = 1'b0;
      respond();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      wait_cnt = 0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!imem_req && n < 50) begin
         next_cycle();
         n++;
      end
      check(name, 32'(imem_req), 32'd1);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!instr_valid && n < 50) begin
         next_cycle();
         n++;
      end
      check(name, 32'(instr_valid), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;

      // Streaming fetch from reset: one instruction per cycle with immediate acks.
      auto_ack = 1'b1; ack_delay = 0; instr_ready = 1'b1;
      do_reset();
      check("s1_rst_req", 32'(imem_req), 32'd0);
      check("s1_rst_addr", 32'(imem_addr), 32'd0);
      check("s1_rst_valid", 32'(instr_valid), 32'd0);
      check("s1_rst_out", instr_out, 32'd0);
      check("s1_rst_pc", 32'(instr_pc), 32'd0);
      check("s1_rst_count", 32'(queue_count), 32'd0);
      wait_req("s1_req");
      check("s1_first_addr", 32'(imem_addr), 32'd0);
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         check("s1_stream_valid", 32'(instr_valid), 32'd1);
         check("s1_stream_pc", 32'(instr_pc), 32'(i));
         check("s1_stream_addr", 32'(imem_addr), 32'(i + 1));
      end

      // Decode stalled: queue fills, fetch stops, then resumes at the next address.
      instr_ready = 1'b0;
      do_reset();
      n = 0;
      while (queue_count != 3'd4 && n < 20) begin
         next_cycle();
         n++;
      end
      check("s2_full", 32'(queue_count), 32'd4);
      next_cycle();
      check("s2_req_idle", 32'(imem_req), 32'd0);
      check("s2_count_hold", 32'(queue_count), 32'd4);
      check("s2_head_pc", 32'(instr_pc), 32'd0);
      instr_ready = 1'b1;
      wait_req("s2_resume_req");
      check("s2_resume_addr", 32'(imem_addr), 32'd4);
      for (int i = 0; i < 6; i++) next_cycle();

      // Redirect while the request waits on a slow memory.
      ack_delay = 3;
      do_reset();
      wait_req("s3_req0");
      check("s3_addr0", 32'(imem_addr), 32'd0);
      redirect = 1'b1; redirect_pc = 10'h120;
      next_cycle();
      check("s3_squash_req", 32'(imem_req), 32'd1);
      check("s3_squash_addr", 32'(imem_addr), 32'd0);
      n = 0;
      while (!(imem_req && imem_addr == 10'h120) && n < 20) begin
         check("s3_no_stale", 32'(instr_valid), 32'd0);
         next_cycle();
         n++;
      end
      check("s3_new_addr", 32'(imem_addr), 32'h120);
      wait_valid("s3_valid");
      check("s3_head_pc", 32'(instr_pc), 32'h120);
`ifdef FETCH_STATS_EN
      check("s3_stat_squashed", stat_squashed, 32'd1);
`endif

      // Redirect coincident with an ack and a pop while two entries are queued.
      auto_ack = 1'b0; instr_ready = 1'b0;
      do_reset();
      wait_req("s4_req0");
      give_ack();
      next_cycle();
      check("s4_addr1", 32'(imem_addr), 32'd1);
      give_ack();
      next_cycle();
      check("s4_count2", 32'(queue_count), 32'd2);
      check("s4_addr2", 32'(imem_addr), 32'd2);
      give_ack();
      instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 10'h055;
      next_cycle();
      check("s4_flush_count", 32'(queue_count), 32'd0);
      check("s4_flush_valid", 32'(instr_valid), 32'd0);
      check("s4_flush_req", 32'(imem_req), 32'd0);
`ifdef FETCH_STATS_EN
      check("s4_stat_fetched", stat_fetched, 32'd2);
      check("s4_stat_squashed", stat_squashed, 32'd3);
`endif
      next_cycle();
      check("s4_req_target", 32'(imem_req), 32'd1);
      check("s4_addr_target", 32'(imem_addr), 32'h055);

      // PC wraps from the top of the address space to zero.
      auto_ack = 1'b1; ack_delay = 0;
      do_reset();
      redirect = 1'b1; redirect_pc = 10'h3FF;
      wait_req("s5_req");
      check("s5_addr_top", 32'(imem_addr), 32'h3FF);
      next_cycle();
      check("s5_addr_wrap", 32'(imem_addr), 32'h000);
      check("s5_head_top", 32'(instr_pc), 32'h3FF);
      next_cycle();
      check("s5_head_wrap", 32'(instr_pc), 32'h000);

      // Reset abandons an outstanding request; a late ack is ignored.
      auto_ack = 1'b0;
      do_reset();
      wait_req("s6_req0");
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      give_ack();
      next_cycle();
      check("s6_count", 32'(queue_count), 32'd0);
      check("s6_valid", 32'(instr_valid), 32'd0);
      check("s6_req", 32'(imem_req), 32'd1);
      check("s6_addr", 32'(imem_addr), 32'd0);
      auto_ack = 1'b1;
      wait_valid("s6_valid_after");
      check("s6_head_pc", 32'(instr_pc), 32'd0);
      for (int i = 0; i < 5; i++) next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
